// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame parser.
// Frame layout: SOF, OP, ADDR, DATA_H, DATA_L, CHK (XOR of the four payload bytes).
package uart_cmd_pkg;

    localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN   = 6;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DATA_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_ADDR = 3'd2,
        ST_DH   = 3'd3,
        ST_DL   = 3'd4,
        ST_CHK  = 3'd5
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] op;
        logic [BYTE_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/cmd_frame_timer.sv
// Inter-byte timeout counter; only built when UART_CMD_PARSER_TIMEOUT_EN is defined.
// expire_c is a combinational one-cycle pulse on the last counted idle cycle.
`ifdef UART_CMD_PARSER_TIMEOUT_EN
module cmd_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A byte strobe in the same cycle always wins over expiry.
    always_comb begin
        expire_c = 1'b0;
        count_d  = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            expire_c = 1'b1;
            count_d  = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/uart_cmd_parser.sv
// Byte-stream command frame parser with a one-entry valid/ready output buffer.
// Define UART_CMD_PARSER_TIMEOUT_EN to compile in the inter-byte timeout (cmd_frame_timer).
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        chk_err,
    output logic        ovf_err,
    output logic        tmo_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_cmd_parser: TIMEOUT_CYCLES must be at least 2");
    end

    state_e     state_q, state_d;
    logic [7:0] xor_q, xor_d;
    cmd_t       stage_q, stage_d;
    cmd_t       cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       chk_err_q, chk_err_d;
    logic       ovf_err_q, ovf_err_d;
    logic       tmo_err_q, tmo_err_d;
    logic       frame_good_c;
    logic       tmo_expire_c;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    cmd_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (rx_valid),
        .enable   (state_q != ST_IDLE),
        .expire_c (tmo_expire_c)
    );
`else
    assign tmo_expire_c = 1'b0;
`endif

    // Frame parser: moves only on byte strobes, or on timeout when compiled in.
    always_comb begin
        state_d      = state_q;
        xor_d        = xor_q;
        stage_d      = stage_q;
        frame_good_c = 1'b0;
        chk_err_d    = 1'b0;
        tmo_err_d    = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SOF_BYTE) begin
                        state_d = ST_OP;
                        xor_d   = '0;
                    end
                end
                ST_OP: begin
                    stage_d.op = rx_byte;
                    xor_d      = xor_q ^ rx_byte;
                    state_d    = ST_ADDR;
                end
                ST_ADDR: begin
                    stage_d.addr = rx_byte;
                    xor_d        = xor_q ^ rx_byte;
                    state_d      = ST_DH;
                end
                ST_DH: begin
                    stage_d.data[15:8] = rx_byte;
                    xor_d              = xor_q ^ rx_byte;
                    state_d            = ST_DL;
                end
                ST_DL: begin
                    stage_d.data[7:0] = rx_byte;
                    xor_d             = xor_q ^ rx_byte;
                    state_d           = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_byte == xor_q) begin
                        frame_good_c = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmo_expire_c) begin
            state_d   = ST_IDLE;
            tmo_err_d = 1'b1;
        end
    end

    // Output buffer: a transfer and a new load may share a cycle; a full, stalled buffer drops.
    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q && !cmd_ready;
        ovf_err_d   = 1'b0;
        if (frame_good_c) begin
            if (cmd_valid_q && !cmd_ready) begin
                ovf_err_d = 1'b1;
            end else begin
                cmd_d       = stage_q;
                cmd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            xor_q       <= '0;
            stage_q     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            xor_q       <= xor_d;
            stage_q     <= stage_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            chk_err_q   <= chk_err_d;
            ovf_err_q   <= ovf_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_q.op;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_data  = cmd_q.data;
    assign chk_err   = chk_err_q;
    assign ovf_err   = ovf_err_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a byte-queue frame model predicts transfers and
// error pulses; a negedge monitor pops and compares. Timeout cases need UART_CMD_PARSER_TIMEOUT_EN.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        chk_err;
    logic        ovf_err;
    logic        tmo_err;

    uart_cmd_parser #(
        .SOF_BYTE       (SOF_DEFAULT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .chk_err   (chk_err),
        .ovf_err   (ovf_err),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected events: transferred commands, and the cycle each pulse/rise should be seen.
    cmd_t xfer_q[$];
    int   load_q[$];
    int   chk_q[$];
    int   ovf_q[$];
    int   tmo_q[$];

    // Reference model state: bytes of the frame in progress plus the buffer contents.
    logic [7:0] frame[$];
    bit         m_full = 1'b0;
    cmd_t       m_cmd  = '0;
    int         idle   = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = ($urandom_range(0, 7) == 0) ? SOF_DEFAULT : 8'($urandom);
        return b;
    endfunction

    // Apply one edge's worth of inputs to the frame/buffer model.
    task automatic model_step(input bit v, input logic [7:0] b, input bit r);
        bit   good;
        bit   xf;
        cmd_t nc;
        good = 1'b0;
        nc   = '0;
        if (v) begin
            idle = 0;
            if (frame.size() != 0 || b == SOF_DEFAULT) frame.push_back(b);
            if (frame.size() == FRAME_LEN) begin
                if ((frame[1] ^ frame[2] ^ frame[3] ^ frame[4]) == frame[5]) begin
                    good    = 1'b1;
                    nc.op   = frame[1];
                    nc.addr = frame[2];
                    nc.data = {frame[3], frame[4]};
                end else begin
                    chk_q.push_back(cyc + 1);
                end
                frame.delete();
            end
        end
`ifdef UART_CMD_PARSER_TIMEOUT_EN
        else if (frame.size() != 0) begin
            idle++;
            if (idle == int'(TMO)) begin
                frame.delete();
                idle = 0;
                tmo_q.push_back(cyc + 1);
            end
        end
`endif
        xf = m_full && r;
        if (xf) xfer_q.push_back(m_cmd);
        if (good) begin
            if (m_full && !r) begin
                ovf_q.push_back(cyc + 1);
            end else begin
                if (!m_full) load_q.push_back(cyc + 1);
                m_cmd  = nc;
                m_full = 1'b1;
            end
        end else if (xf) begin
            m_full = 1'b0;
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit r);
        rx_valid  = v;
        rx_byte   = v ? b : 8'h00;
        cmd_ready = r;
        model_step(v, b, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, r);
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit r);
        foreach (b[i]) cycle(1'b1, b[i], r);
    endtask

    // Checksum byte is always derived from the XOR rule; bad=1 corrupts it.
    task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data,
                              input bit bad, input bit r_body, input bit r_chk);
        logic [7:0] x;
        x = op ^ addr ^ data[15:8] ^ data[7:0];
        if (bad) x = x ^ 8'h01;
        cycle(1'b1, SOF_DEFAULT, r_body);
        cycle(1'b1, op, r_body);
        cycle(1'b1, addr, r_body);
        cycle(1'b1, data[15:8], r_body);
        cycle(1'b1, data[7:0], r_body);
        cycle(1'b1, x, r_chk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " cmd_valid"}, cmd_valid == 1'b0, cmd_valid, 0);
        check({tag, " cmd_op"},    cmd_op == 8'h00,    cmd_op, 0);
        check({tag, " cmd_addr"},  cmd_addr == 8'h00,  cmd_addr, 0);
        check({tag, " cmd_data"},  cmd_data == 16'h0,  cmd_data, 0);
        check({tag, " errs"},      {chk_err, ovf_err, tmo_err} == 3'b000, {chk_err, ovf_err, tmo_err}, 0);
    endtask

    // Reset held across one edge; model drops the frame and the buffered command.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        @(posedge clk);
        #1;
        check_zero(tag);
        frame.delete();
        m_full = 1'b0;
        idle   = 0;
        rst    = 1'b0;
    endtask

    // Monitor: compares every observable DUT event against the expected queues.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_cmd   = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            int   e;
            cmd_t c;
            if (chk_err) begin
                if (chk_q.size() == 0) check("chk_err unexpected", 1'b0, 1, 0);
                else begin e = chk_q.pop_front(); check("chk_err cycle", cyc == e, cyc, e); end
            end
            if (ovf_err) begin
                if (ovf_q.size() == 0) check("ovf_err unexpected", 1'b0, 1, 0);
                else begin e = ovf_q.pop_front(); check("ovf_err cycle", cyc == e, cyc, e); end
            end
            if (tmo_err) begin
                if (tmo_q.size() == 0) check("tmo_err unexpected", 1'b0, 1, 0);
                else begin e = tmo_q.pop_front(); check("tmo_err cycle", cyc == e, cyc, e); end
            end
            if (cmd_valid && !prev_valid) begin
                if (load_q.size() == 0) check("cmd_valid rise unexpected", 1'b0, 1, 0);
                else begin e = load_q.pop_front(); check("cmd_valid rise cycle", cyc == e, cyc, e); end
            end
            if (prev_valid && !prev_ready && cmd_valid)
                check("held fields stable", {cmd_op, cmd_addr, cmd_data} == prev_cmd,
                      {cmd_op, cmd_addr, cmd_data}, prev_cmd);
            if (cmd_valid && cmd_ready) begin
                if (xfer_q.size() == 0) check("transfer unexpected", 1'b0, {cmd_op, cmd_addr, cmd_data}, 0);
                else begin
                    c = xfer_q.pop_front();
                    check("transfer fields", {cmd_op, cmd_addr, cmd_data} == c, {cmd_op, cmd_addr, cmd_data}, c);
                end
            end
            prev_valid = cmd_valid;
            prev_ready = cmd_ready;
            prev_cmd   = {cmd_op, cmd_addr, cmd_data};
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        idle_cycles(2, 1'b1);

        // Single good frame, consumer always ready.
        send_frame(8'h10, 8'h22, 16'h1234, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);

        // Leading junk is discarded silently.
        send_bytes('{8'h00, 8'hFF}, 1'b1);
        send_frame(8'h10, 8'h22, 16'h1234, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);

        // Bad checksum, then recovery on the next good frame.
        send_bytes('{8'hA5, 8'h10, 8'h22, 8'h12, 8'h34, 8'h0D}, 1'b1);
        idle_cycles(2, 1'b1);
        send_frame(8'h3C, 8'h44, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);

        // Stalled consumer: second frame overflows, first is held then transferred.
        send_frame(8'h01, 8'h11, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        send_frame(8'h02, 8'h22, 16'h5555, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        idle_cycles(4, 1'b1);

        // Full buffer with ready on the checksum edge: swap without overflow.
        send_frame(8'h07, 8'h70, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        send_frame(8'h08, 8'h80, 16'hF0F0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3, 1'b0);
        idle_cycles(3, 1'b1);

        // SOF value inside the payload is plain data.
        send_frame(SOF_DEFAULT, SOF_DEFAULT, 16'hA5A5, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);

        // Reset mid-frame with a command still buffered.
        send_frame(8'h55, 8'h66, 16'h7788, 1'b0, 1'b0, 1'b0);
        send_bytes('{8'hA5, 8'h10, 8'h22}, 1'b0);
        do_reset("mid-frame reset");
        send_bytes('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 1'b1);
        idle_cycles(3, 1'b1);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
        // Stall after OP: timeout returns to IDLE, then a full frame parses.
        send_bytes('{8'hA5, 8'h10}, 1'b1);
        idle_cycles(int'(TMO) + 3, 1'b1);
        send_frame(8'h10, 8'h22, 16'h1234, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);
`endif

        // Randomized stream: junk, good and corrupted frames, gaps, random backpressure.
        for (int n = 0; n < 200; n++) begin
            int         kind;
            logic [7:0] fb[6];
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                cycle(1'b1, rnd_byte(), 1'($urandom_range(0, 1)));
            end else begin
                fb[0] = SOF_DEFAULT;
                for (int k = 1; k < 5; k++) fb[k] = rnd_byte();
                fb[5] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
                if (kind == 9) fb[5] = fb[5] ^ 8'($urandom_range(1, 255));
                for (int k = 0; k < 6; k++) begin
                    idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
                    cycle(1'b1, fb[k], 1'($urandom_range(0, 1)));
                end
            end
        end
        idle_cycles(6, 1'b1);

        check("pending transfers", xfer_q.size() == 0, xfer_q.size(), 0);
        check("pending chk_err",   chk_q.size() == 0,  chk_q.size(), 0);
        check("pending ovf_err",   ovf_q.size() == 0,  ovf_q.size(), 0);
        check("pending tmo_err",   tmo_q.size() == 0,  tmo_q.size(), 0);
        check("pending loads",     load_q.size() == 0, load_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
